reg_issue: RTL and testbench
============================

# reg_issue

Operand-issue stage of the 8-bit CPU, directly upstream of the ALU. It decodes a 16-bit instruction and reads two operands from an internal 8×8 register file, with bypass from the writeback port. A per-register scoreboard stalls on pending results. Accepted operations are held in an output register that feeds the ALU's a, b and op inputs through a valid/ready handshake.

## Interface
- DATA_W, 8, operand and register width.
- NREGS, 8, number of architectural registers; register 0 reads as zero.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; one clock; polarity and synchronicity fixed.
- in_valid  input  1  in_instr holds a valid instruction.
- in_ready  output  1  the stage accepts in_instr this cycle.
- in_instr  input  16  instruction; fields defined under Operation.
- wb_en  input  1  writeback strobe.
- wb_addr  input  3  writeback register index.
- wb_data  input  8  writeback value.
- out_valid  output  1  out_a, out_b, out_op and out_rd are valid.
- out_ready  input  1  the downstream stage takes the output this cycle.
- out_a  output  8  ALU operand a.
- out_b  output  8  ALU operand b.
- out_op  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- out_rd  output  3  destination register, passed down to writeback.

## Operation
- Instruction fields:
  - [15] i: immediate select.
  - [14:12] op.
  - [11:9] rd.
  - [8:6] rs.
  - [5:3] rt.
  - [5:0] imm6, used when i=1.
- Register file read:
  - Two combinational read ports, indexed by rs and rt.
  - When wb_en=1 and wb_addr equals the read index (index ≠ 0), the port returns wb_data (bypass).
  - Index 0 always reads 8'h00. Writes to register 0 are ignored.
- Scoreboard: pending[7:0].
  - An accepted instruction with rd≠0 sets pending[rd].
  - wb_en clears pending[wb_addr].
  - If a set and a clear hit the same index in the same cycle, the set wins.
- Hazard, asserted when any of the following holds:
  - pending[rs] is set and rs is not being written back this cycle.
  - pending[rt] is set, i=0, and rt is not being written back this cycle.
  - pending[rd] is set and rd≠0 (write-after-write stall).
- Accept rule:
  - in_ready = !hazard && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
- On accept, the output register loads:
  - out_a = rs operand.
  - out_b = rt operand, or the immediate when enabled.
  - out_op = op.
  - out_rd = rd.
  - out_valid is set to 1.
- Output hold and drain:
  - Outputs hold steady while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and no new accept occurs in that cycle.
- Op codes outside {000, 001, 010, 110, 111} pass through unchanged; the ALU defines their result.

## Timing
- Issue latency is 1 cycle: an instruction accepted at edge N is presented on out_* after edge N.
- Full throughput is one instruction per cycle with no hazards and out_ready held high.
- in_ready is combinational from in_instr, pending, wb_* and out_ready. It does not depend on in_valid.
- Register file write happens at the wb_en edge; bypass covers reads in the same cycle.
- A writeback that coincides with a stalled instruction clears the hazard in that same cycle, so the instruction issues with zero extra delay.
- Reset values:
  - All registers 8'h00; pending 0.
  - out_valid 0; out_a, out_b 8'h00; out_op 3'b000; out_rd 3'b000.
  - in_ready is 1 after reset.
- Reset asserted mid-operation discards the held output and all scoreboard state. A wb_en in the same cycle as reset is ignored.

## Configuration
- REG_ISSUE_IMM_EN defined: with i=1, out_b = imm6 sign-extended to 8 bits, and rt is excluded from the hazard check.
- REG_ISSUE_IMM_EN undefined: bit 15 is ignored, out_b is always the rt operand, and the rt hazard check always applies.

## Structure
- Shared package cpu_pkg holds:
  - DATA_W and NREGS.
  - ALU op constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT.
  - Instruction field bit positions.
- Sub-module reg_file_8x8: two read ports, one write port, writeback bypass, register 0 hardwired to zero.
- Scoreboard, hazard logic and the output register live in reg_issue.

## Test plan
- After reset, write r1=8'h05 and r2=8'h03, then issue add r3,r1,r2 (op 010) -> out_a=8'h05, out_b=8'h03, out_op=010, out_rd=3 one cycle after accept.
- Issue with r3 pending, then a dependent sub r4,r3,r1 -> in_ready=0 until wb_en with wb_addr=3 and wb_data=8'h08; the instruction issues in that same cycle with out_a=8'h08.
- Issue with out_ready held 0 for 3 cycles -> out_* stable, in_ready=0; on release, the next instruction issues back-to-back.
- With REG_ISSUE_IMM_EN: i=1, imm6=6'h3E -> out_b=8'hFE, no stall on a pending rt. Without the macro -> out_b = the rt value.
- Write r0=8'hAA, then read rs=0 -> out_a=8'h00; an instruction with rd=0 leaves pending unchanged.
- Assert reset while out_valid=1 and pending≠0 -> out_valid=0, pending=0, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, ALU op codes and instruction field positions
//            for the 8-bit CPU.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int I_BIT  = 15;
    localparam int OP_HI  = 14;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int RT_HI  = 5;
    localparam int RT_LO  = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

endpackage
`default_nettype wire

// File: rtl/reg_file_8x8.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_8x8
// Purpose  : Two-read / one-write register file with writeback bypass;
//            register 0 is hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_8x8
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle writeback is forwarded so readers never see a stale value.
    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
        if (we && (waddr == raddr_a)) rdata_a = wdata;
        if (we && (waddr == raddr_b)) rdata_b = wdata;
        if (raddr_a == '0) rdata_a = '0;
        if (raddr_b == '0) rdata_b = '0;
    end

endmodule
`default_nettype wire

// File: rtl/reg_issue.sv
`default_nettype none
// ============================================================================
// Module   : reg_issue
// Purpose  : Operand-issue stage: decode, register read with bypass,
//            scoreboard hazard stall and registered ALU handshake output.
//            Optional macro REG_ISSUE_IMM_EN enables the sign-extended
//            6-bit immediate on operand b.
// Revision : 1.0 - initial release
// ============================================================================
module reg_issue
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_op,
    output logic [ADDR_W-1:0] out_rd
);

    logic [2:0]        op;
    logic [ADDR_W-1:0] rd, rs, rt;
    logic              use_imm;
    logic [DATA_W-1:0] rdata_a, rdata_b, b_sel;
    logic              hazard, accept;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [NREGS-1:0]  pending_q, pending_d;

    assign op = in_instr[OP_HI:OP_LO];
    assign rd = in_instr[RD_HI:RD_LO];
    assign rs = in_instr[RS_HI:RS_LO];
    assign rt = in_instr[RT_HI:RT_LO];

`ifdef REG_ISSUE_IMM_EN
    logic [2:0] unused_bits;
    assign unused_bits = in_instr[2:0];
    assign use_imm     = in_instr[I_BIT];
    assign b_sel       = use_imm ? {{(DATA_W-6){in_instr[IMM_HI]}}, in_instr[IMM_HI:IMM_LO]}
                                 : rdata_b;
`else
    logic [3:0] unused_bits;
    assign unused_bits = {in_instr[I_BIT], in_instr[2:0]};
    assign use_imm     = 1'b0;
    assign b_sel       = rdata_b;
`endif

    reg_file_8x8 u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // A source being written back this cycle is satisfied through the bypass.
    always_comb begin
        hazard = 1'b0;
        if (pending_q[rs] && !(wb_en && (wb_addr == rs)))             hazard = 1'b1;
        if (pending_q[rt] && !use_imm && !(wb_en && (wb_addr == rt))) hazard = 1'b1;
        if (pending_q[rd] && (rd != '0))                              hazard = 1'b1;
    end

    assign in_ready = !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        pending_d = pending_q;
        if (wb_en) pending_d[wb_addr] = 1'b0;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = rdata_a;
            b_d     = b_sel;
            op_d    = op;
            rd_d    = rd;
            if (rd != '0) pending_d[rd] = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            rd_q      <= '0;
            pending_q <= '0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_op    = op_q;
    assign out_rd    = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_issue
// Purpose  : Directed self-checking bench for reg_issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [2:0]  out_op;
    logic [2:0]  out_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_issue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_rd    (out_rd)
    );

    function automatic logic [15:0] enc(input logic i, input logic [2:0] op,
                                        input logic [2:0] rd, input logic [2:0] rs,
                                        input logic [2:0] rt);
        return {i, op, rd, rs, rt, 3'b000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [7:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        settle();
        checks++;
        if ({out_valid, out_a, out_b, out_op, out_rd} !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000000",
                     {out_valid, out_a, out_b, out_op, out_rd});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        wb_write(3'd1, 8'h05);
        wb_write(3'd2, 8'h03);
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b010, 3'd3, 3'd1, 3'd2);
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL add_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_a, out_b, out_op, out_rd} !== {1'b1, 8'h05, 8'h03, 3'b010, 3'd3}) begin
            errors++;
            $display("FAIL add_out: got v=%b a=%h b=%h op=%b rd=%0d expected v=1 a=05 b=03 op=010 rd=3",
                     out_valid, out_a, out_b, out_op, out_rd);
        end
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b110, 3'd4, 3'd3, 3'd1);
        settle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL raw_stall: got in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall_hold: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h08;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL raw_wb_release: got in_ready=%b expected 1", in_ready);
        end
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, out_a, out_b, out_op, out_rd} !== {1'b1, 8'h08, 8'h05, 3'b110, 3'd4}) begin
            errors++;
            $display("FAIL raw_issue: got v=%b a=%h b=%h op=%b rd=%0d expected v=1 a=08 b=05 op=110 rd=4",
                     out_valid, out_a, out_b, out_op, out_rd);
        end
        // r4 now pending: write-after-write must stall until it is written back
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b000, 3'd4, 3'd1, 3'd2);
        settle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL waw_stall: got in_ready=%b expected 0", in_ready);
        end
        in_valid = 1'b0;
        wb_write(3'd4, 8'h03);
        in_valid = 1'b1;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL waw_release: got in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_a, out_b, out_op, out_rd} !== {1'b1, 8'h05, 8'h03, 3'b000, 3'd4}) begin
            errors++;
            $display("FAIL waw_issue: got v=%b a=%h b=%h op=%b rd=%0d expected v=1 a=05 b=03 op=000 rd=4",
                     out_valid, out_a, out_b, out_op, out_rd);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b001, 3'd5, 3'd1, 3'd2);
        tick();
        in_instr = enc(1'b0, 3'b010, 3'd6, 3'd1, 3'd2);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({in_ready, out_valid, out_a, out_b, out_op, out_rd} !==
                {1'b0, 1'b1, 8'h05, 8'h03, 3'b001, 3'd5}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got rdy=%b v=%b a=%h b=%h op=%b rd=%0d expected rdy=0 v=1 a=05 b=03 op=001 rd=5",
                         k, in_ready, out_valid, out_a, out_b, out_op, out_rd);
            end
            tick();
        end
        out_ready = 1'b1;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_op, out_rd} !== {1'b1, 3'b010, 3'd6}) begin
            errors++;
            $display("FAIL b2b_first: got v=%b op=%b rd=%0d expected v=1 op=010 rd=6", out_valid, out_op, out_rd);
        end
        in_instr = enc(1'b0, 3'b111, 3'd7, 3'd2, 3'd1);
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_a, out_b, out_op, out_rd} !== {1'b1, 8'h03, 8'h05, 3'b111, 3'd7}) begin
            errors++;
            $display("FAIL b2b_second: got v=%b a=%h b=%h op=%b rd=%0d expected v=1 a=03 b=05 op=111 rd=7",
                     out_valid, out_a, out_b, out_op, out_rd);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_imm();
        // rt field of imm6 3E is r7, which is still pending
        in_valid = 1'b1; in_instr = {1'b1, 3'b010, 3'd2, 3'd1, 6'h3E};
        settle();
`ifdef REG_ISSUE_IMM_EN
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL imm_no_stall: got in_ready=%b expected 1", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_a, out_b} !== {1'b1, 8'h05, 8'hFE}) begin
            errors++;
            $display("FAIL imm_out: got v=%b a=%h b=%h expected v=1 a=05 b=fe", out_valid, out_a, out_b);
        end
`else
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL imm_rt_stall: got in_ready=%b expected 0", in_ready);
        end
        wb_en = 1'b1; wb_addr = 3'd7; wb_data = 8'h42;
        settle();
        tick();
        wb_en = 1'b0;
        checks++;
        if ({out_valid, out_a, out_b} !== {1'b1, 8'h05, 8'h42}) begin
            errors++;
            $display("FAIL imm_rt_out: got v=%b a=%h b=%h expected v=1 a=05 b=42", out_valid, out_a, out_b);
        end
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_r0();
        wb_write(3'd0, 8'hAA);
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b001, 3'd0, 3'd0, 3'd1);
        tick();
        checks++;
        if ({out_valid, out_a, out_b, out_rd} !== {1'b1, 8'h00, 8'h05, 3'd0}) begin
            errors++;
            $display("FAIL r0_read: got v=%b a=%h b=%h rd=%0d expected v=1 a=00 b=05 rd=0",
                     out_valid, out_a, out_b, out_rd);
        end
        in_instr = enc(1'b0, 3'b000, 3'd1, 3'd0, 3'd1);
        settle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL r0_not_pending: got in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b010, 3'd3, 3'd1, 3'd2);
        tick();
        in_valid = 1'b0;
        reset = 1'b1; wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h77;
        tick();
        reset = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = enc(1'b0, 3'b010, 3'd5, 3'd3, 3'd2);
        settle();
        checks++;
        if ({out_valid, out_a, out_b, out_op, out_rd, in_ready} !== 24'h000001) begin
            errors++;
            $display("FAIL mid_reset: got v=%b a=%h b=%h op=%b rd=%0d rdy=%b expected all zero rdy=1",
                     out_valid, out_a, out_b, out_op, out_rd, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_a, out_b, out_rd} !== {1'b1, 8'h00, 8'h00, 3'd5}) begin
            errors++;
            $display("FAIL mid_reset_regs: got v=%b a=%h b=%h rd=%0d expected v=1 a=00 b=00 rd=5",
                     out_valid, out_a, out_b, out_rd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_hazard();
        test_back_to_back();
        test_imm();
        test_r0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
